// File: rtl/l1_miss_ctrl.sv
// l1_miss_ctrl: miss/refill sequencer for the two-way L1 data cache.
// Stalls the CPU on load misses and stores, refills a whole line word by
// word from the next level, forwards every store (write-through, no
// write-allocate) and keeps saturating load hit/miss counters.
module l1_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_w_data,
    output logic                  cpu_stall,
    input  logic                  cache_hit,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_mark_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int WORDS = LINE_SIZE / (DATA_WIDTH / 8);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = $clog2(DATA_WIDTH / 8);
    localparam int OFF   = $clog2(LINE_SIZE);

    typedef enum logic [1:0] {IDLE, REFILL, DONE, WRITE} state_t;

    state_t                state;
    logic [CW-1:0]         word_cnt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  load_req;
    logic                  last_word;

    assign load_req  = cpu_valid && !cpu_we;
    assign word_addr = line_base + ADDR_WIDTH'({word_cnt, {BW{1'b0}}});
    assign last_word = (word_cnt == CW'(WORDS - 1));

    // Sequencer state, refill bookkeeping, store latch and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            line_base  <= '0;
            st_addr    <= '0;
            st_data    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req && cache_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                    end else if (load_req) begin
                        line_base <= {cpu_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        word_cnt  <= '0;
                        if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                        state     <= REFILL;
                    end else if (cpu_valid) begin
                        st_addr <= cpu_addr;
                        st_data <= cpu_w_data;
                        state   <= WRITE;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        word_cnt <= word_cnt + CW'(1);
                        if (last_word) state <= DONE;
                    end
                end
                // One settle cycle for the L1 arrays before the re-lookup.
                DONE:    state <= IDLE;
                WRITE:   if (mem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode; fills and stall release follow mem_ready in the same cycle.
    always_comb begin
        cpu_stall       = 1'b0;
        fill_en         = 1'b0;
        fill_addr       = '0;
        fill_data       = '0;
        fill_mark_valid = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_w_data      = '0;
        case (state)
            IDLE: begin
                // Gated by rst so every output is quiet while reset is held.
                cpu_stall = !rst && cpu_valid && (cpu_we || !cache_hit);
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = word_addr;
                if (mem_ready) begin
                    fill_en         = 1'b1;
                    fill_addr       = word_addr;
                    fill_data       = mem_r_data;
                    fill_mark_valid = last_word;
                end
            end
            DONE: cpu_stall = 1'b1;
            WRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = st_addr;
                mem_w_data = st_data;
                cpu_stall  = !mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_miss_ctrl.sv
// Self-checking bench for l1_miss_ctrl. The reference model tracks which
// lines the L1 holds, the expected per-cycle handshake of each access and
// saturating counter values. Counters are built 4 bits wide so saturation
// is reachable in a short run.
module tb_l1_miss_ctrl;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic            clk, rst;
    logic            cpu_valid, cpu_we, cpu_stall, cache_hit;
    logic [31:0]     cpu_addr, cpu_w_data;
    logic            fill_en, fill_mark_valid;
    logic [31:0]     fill_addr, fill_data;
    logic            mem_req, mem_we, mem_ready;
    logic [31:0]     mem_addr, mem_w_data, mem_r_data;
    logic [CNTW-1:0] hit_count, miss_count;

    int errors = 0;
    int checks = 0;
    int hit_m  = 0;
    int miss_m = 0;
    bit line_ok [logic [31:0]];

    l1_miss_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(16), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_w_data(cpu_w_data),
        .cpu_stall(cpu_stall), .cache_hit(cache_hit),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_mark_valid(fill_mark_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_ready(mem_ready), .mem_r_data(mem_r_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next-level memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_r_data = mem_fn(mem_addr);

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One load from request to CPU release; hold_word stalls mem_ready for
    // hold_len cycles before that word (hold_word < 0 disables).
    task automatic do_load(input logic [31:0] addr, input int hold_word, input int hold_len);
        logic [31:0] base = {addr[31:4], 4'b0};
        bit          hit  = line_ok.exists(base);
        int          fills = 0;
        int          marks = 0;
        int          nh;
        @(negedge clk);
        cpu_valid = 1; cpu_we = 0; cpu_addr = addr; cache_hit = hit;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (cpu_stall !== !hit) begin errors++; $display("FAIL load_stall addr=%h got=%b want=%b", addr, cpu_stall, !hit); end
        checks++;
        if (mem_req !== 0 || fill_en !== 0) begin errors++; $display("FAIL idle_quiet mem_req=%b fill_en=%b want 0/0", mem_req, fill_en); end
        if (hit) begin
            hit_m = sat(hit_m);
            @(posedge clk);
        end else begin
            miss_m = sat(miss_m);
            @(posedge clk);
            for (int w = 0; w < 4; w++) begin
                nh = (w == hold_word) ? hold_len : 0;
                for (int h = 0; h <= nh; h++) begin
                    @(negedge clk);
                    mem_ready = (h == nh);
                    #1;
                    checks++;
                    if (cpu_stall !== 1 || mem_req !== 1 || mem_we !== 0 || mem_addr !== base + 32'(4 * w)) begin
                        errors++;
                        $display("FAIL refill_req w=%0d stall=%b req=%b we=%b addr=%h want 1/1/0/%h",
                                 w, cpu_stall, mem_req, mem_we, mem_addr, base + 32'(4 * w));
                    end
                    checks++;
                    if (fill_en !== mem_ready) begin errors++; $display("FAIL fill_en w=%0d got=%b want=%b", w, fill_en, mem_ready); end
                    if (mem_ready) begin
                        fills++;
                        marks += int'(fill_mark_valid);
                        checks++;
                        if (fill_addr !== base + 32'(4 * w) || fill_data !== mem_fn(base + 32'(4 * w)) ||
                            fill_mark_valid !== (w == 3)) begin
                            errors++;
                            $display("FAIL fill_word w=%0d addr=%h data=%h mark=%b want %h/%h/%b", w, fill_addr,
                                     fill_data, fill_mark_valid, base + 32'(4 * w), mem_fn(base + 32'(4 * w)), w == 3);
                        end
                    end
                    @(posedge clk);
                end
            end
            // settle cycle: the L1 already reports the hit but the CPU stays held
            @(negedge clk);
            cache_hit = 1; mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (cpu_stall !== 1 || mem_req !== 0 || fill_en !== 0) begin
                errors++; $display("FAIL done_cycle stall=%b req=%b fill=%b want 1/0/0", cpu_stall, mem_req, fill_en);
            end
            line_ok[base] = 1;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (cpu_stall !== 0 || mem_req !== 0) begin
                errors++; $display("FAIL relookup stall=%b req=%b want 0/0", cpu_stall, mem_req);
            end
            hit_m = sat(hit_m);
            @(posedge clk);
            checks++;
            if (fills != 4 || marks != 1) begin errors++; $display("FAIL fill_pulses fills=%0d marks=%0d want 4/1", fills, marks); end
        end
        @(negedge clk);
        cpu_valid = 0; cache_hit = 0; mem_ready = 0;
        #1;
        checks++;
        if (hit_count !== CNTW'(hit_m) || miss_count !== CNTW'(miss_m) || cpu_stall !== 0) begin
            errors++;
            $display("FAIL counters hit=%0d miss=%0d stall=%b want %0d/%0d/0", hit_count, miss_count, cpu_stall, hit_m, miss_m);
        end
    endtask

    // One store; mem_ready arrives after wait_n not-ready WRITE cycles.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int wait_n);
        int stalls = 0;
        @(negedge clk);
        cpu_valid = 1; cpu_we = 1; cpu_addr = addr; cpu_w_data = data;
        cache_hit = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
        #1;
        stalls += int'(cpu_stall);
        checks++;
        if (cpu_stall !== 1 || mem_req !== 0) begin errors++; $display("FAIL store_idle stall=%b req=%b want 1/0", cpu_stall, mem_req); end
        @(posedge clk);
        for (int i = 0; i <= wait_n; i++) begin
            @(negedge clk);
            mem_ready = (i == wait_n);
            cpu_addr = $urandom; cpu_w_data = $urandom;
            #1;
            stalls += int'(cpu_stall);
            checks++;
            if (mem_req !== 1 || mem_we !== 1 || mem_addr !== addr || mem_w_data !== data ||
                cpu_stall !== !mem_ready || fill_en !== 0) begin
                errors++;
                $display("FAIL store_write i=%0d req=%b we=%b addr=%h data=%h stall=%b want 1/1/%h/%h/%b",
                         i, mem_req, mem_we, mem_addr, mem_w_data, cpu_stall, addr, data, !mem_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        cpu_valid = 0; cpu_we = 0; mem_ready = 0; cache_hit = 0;
        #1;
        checks++;
        if (stalls != wait_n + 1 || cpu_stall !== 0 || mem_req !== 0 ||
            hit_count !== CNTW'(hit_m) || miss_count !== CNTW'(miss_m)) begin
            errors++;
            $display("FAIL store_end stalls=%0d stall=%b req=%b hit=%0d miss=%0d want %0d/0/0/%0d/%0d",
                     stalls, cpu_stall, mem_req, hit_count, miss_count, wait_n + 1, hit_m, miss_m);
        end
    endtask

    task automatic test_reset();
        rst = 1; cpu_valid = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_w_data = 0;
        cache_hit = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({cpu_stall, fill_en, fill_addr, fill_data, fill_mark_valid, mem_req, mem_we,
             mem_addr, mem_w_data, hit_count, miss_count} !== '0) begin
            errors++; $display("FAIL reset_outputs stall=%b req=%b hit=%0d miss=%0d want all 0", cpu_stall, mem_req, hit_count, miss_count);
        end
        rst = 0; cpu_valid = 0; mem_ready = 0;
        #1;
        checks++;
        if (cpu_stall !== 0 || mem_req !== 0) begin errors++; $display("FAIL reset_idle stall=%b req=%b want 0/0", cpu_stall, mem_req); end
    endtask

    task automatic test_load_miss();
        do_load(32'h0000_1234, -1, 0);
        checks++;
        if (miss_count !== 4'd1 || hit_count !== 4'd1) begin
            errors++; $display("FAIL first_miss miss=%0d hit=%0d want 1/1", miss_count, hit_count);
        end
    endtask

    task automatic test_load_hit();
        do_load(32'h0000_1238, -1, 0);
        checks++;
        if (hit_count !== 4'd2 || miss_count !== 4'd1) begin
            errors++; $display("FAIL repeat_hit hit=%0d miss=%0d want 2/1", hit_count, miss_count);
        end
    endtask

    task automatic test_store();
        do_store(32'h0000_2000, 32'hDEAD_BEEF, 1);
        do_store(32'h0000_2004, 32'h1234_5678, 0);
        do_store(32'h0000_1230, 32'hCAFE_F00D, 3);
    endtask

    task automatic test_refill_wait();
        do_load(32'h0000_5008, 2, 3);
        do_load(32'h0000_6000, 0, 2);
    endtask

    task automatic test_reset_mid_refill();
        bit marked = 0;
        @(negedge clk);
        cpu_valid = 1; cpu_we = 0; cpu_addr = 32'h0000_3004; cache_hit = 0; mem_ready = 0;
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            mem_ready = 1;
            #1;
            if (fill_mark_valid === 1) marked = 1;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1; mem_ready = 1;
        #1;
        if (fill_mark_valid === 1) marked = 1;
        checks++;
        if ({cpu_stall, fill_en, fill_addr, fill_data, fill_mark_valid, mem_req, mem_we,
             mem_addr, mem_w_data, hit_count, miss_count} !== '0 || marked) begin
            errors++;
            $display("FAIL reset_mid_refill stall=%b fill=%b req=%b hit=%0d miss=%0d marked=%b want all 0",
                     cpu_stall, fill_en, mem_req, hit_count, miss_count, marked);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 0; cpu_valid = 0; mem_ready = 0;
        hit_m = 0; miss_m = 0;
        do_load(32'h0000_3004, -1, 0);
    endtask

    task automatic test_saturation();
        int i = 0;
        while (miss_m < CMAX) begin
            do_load(32'h0001_0000 + 32'(16 * i), -1, 0);
            i++;
        end
        do_load(32'h0001_0000 + 32'(16 * i), 1, 1);
        checks++;
        if (miss_count !== 4'hF || hit_count !== 4'hF) begin
            errors++; $display("FAIL saturate miss=%0d hit=%0d want 15/15", miss_count, hit_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 30; n++) begin
            a = 32'h0008_0000 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 2) == 0)
                do_store(a, $urandom, $urandom_range(0, 3));
            else
                do_load(a, $urandom_range(0, 4) == 0 ? -1 : $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store();
        test_refill_wait();
        test_reset_mid_refill();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
